// File: rtl/and16_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : and16_bist
// Purpose  : Self-test sequencer for a 16-bit bitwise AND unit; walks a fixed
//            vector set and reports pass/fail, error count and first failure.
// Revision : 1.0 - initial release
// ============================================================================
module and16_bist #(
    parameter int SETTLE       = 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] dut_a,
    output logic [15:0] dut_b,
    input  logic [15:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [2:0]  fail_index,
    output logic [15:0] fail_value
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] c_LAST_IDX    = 3'd5;
    localparam logic [2:0] c_NO_FAIL     = 3'd7;
    localparam logic [3:0] c_ERR_MAX     = 4'd15;
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

    state_t      r_state, w_state_next;
    logic [2:0]  r_idx, w_idx_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [15:0] r_a, w_a_next;
    logic [15:0] r_b, w_b_next;
    logic [3:0]  r_err, w_err_next;
    logic [2:0]  r_fidx, w_fidx_next;
    logic [15:0] r_fval, w_fval_next;
    logic        w_mismatch;
    logic [31:0] w_first_vec;
    logic [31:0] w_next_vec;

    // Operand pairs packed as {a, b}; the expected result is never stored.
    function automatic logic [31:0] rom_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_vec = {16'h0000, 16'h0000};
            3'd1:    rom_vec = {16'h0000, 16'hFFFF};
            3'd2:    rom_vec = {16'hFFFF, 16'hFFFF};
            3'd3:    rom_vec = {16'hAAAA, 16'h5555};
            3'd4:    rom_vec = {16'h3CC3, 16'h0FF0};
            3'd5:    rom_vec = {16'h1234, 16'h9876};
            default: rom_vec = 32'h0;
        endcase
    endfunction

    assign w_first_vec = rom_vec(3'd0);
    assign w_next_vec  = rom_vec(r_idx + 3'd1);
    assign w_mismatch  = (dut_out != (r_a & r_b));

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_err_next   = r_err;
        w_fidx_next  = r_fidx;
        w_fval_next  = r_fval;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_DRIVE;
                    w_idx_next   = 3'd0;
                    w_cnt_next   = 4'd0;
                    w_a_next     = w_first_vec[31:16];
                    w_b_next     = w_first_vec[15:0];
                    w_err_next   = 4'd0;
                    w_fidx_next  = c_NO_FAIL;
                    w_fval_next  = 16'h0000;
                end
            end
            S_DRIVE: begin
                w_state_next = S_WAIT;
                w_cnt_next   = 4'd0;
            end
            S_WAIT: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    if (r_err != c_ERR_MAX) begin
                        w_err_next = r_err + 4'd1;
                    end
                    if (r_fidx == c_NO_FAIL) begin
                        w_fidx_next = r_idx;
                        w_fval_next = dut_out;
                    end
                end
                if ((w_mismatch && STOP_ON_FAIL) || (r_idx == c_LAST_IDX)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_DRIVE;
                    w_idx_next   = r_idx + 3'd1;
                    w_a_next     = w_next_vec[31:16];
                    w_b_next     = w_next_vec[15:0];
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_err   <= 4'd0;
            r_fidx  <= c_NO_FAIL;
            r_fval  <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_err   <= w_err_next;
            r_fidx  <= w_fidx_next;
            r_fval  <= w_fval_next;
        end
    end

    assign dut_a      = r_a;
    assign dut_b      = r_b;
    assign busy       = (r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_err == 4'd0);
    assign err_count  = r_err;
    assign fail_index = r_fidx;
    assign fail_value = r_fval;

endmodule
`default_nettype wire

// File: tb/tb_and16_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_and16_bist
// Purpose  : Scoreboard bench for and16_bist with a faultable AND unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_and16_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start      [3];
    int          mode       [3];
    logic [5:0]  fmask      [3];
    logic [15:0] fxor       [3];
    logic [15:0] dut_a      [3];
    logic [15:0] dut_b      [3];
    logic [15:0] dut_out    [3];
    logic        busy       [3];
    logic        done       [3];
    logic        pass       [3];
    logic [3:0]  err_count  [3];
    logic [2:0]  fail_index [3];
    logic [15:0] fail_value [3];
    logic [15:0] pre_and    [3];

    logic [15:0] va [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234};
    logic [15:0] vb [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555, 16'h0FF0, 16'h9876};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          g;
        int          lat;
        int          nvec;
        logic [3:0]  err;
        logic [2:0]  fidx;
        logic [15:0] fval;
        logic        pss;
        logic [15:0] fin_and;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, g, act, exp);
        end
    endtask

    function automatic logic vec_hit(input logic [15:0] a, input logic [15:0] b, input logic [5:0] m);
        for (int k = 0; k < 6; k++)
            if (m[k] && a == va[k] && b == vb[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Unit modes: 0 correct, 1 stuck at zero, 2 three-register delay,
    // 3 result XOR-corrupted on the vectors selected by the mask.
    function automatic exp_t model(input int g, input int md, input logic [5:0] m,
                                   input logic [15:0] xv, input logic [15:0] pre);
        exp_t        e;
        int          settle = (g == 2) ? 4 : 1;
        bit          stop   = (g == 1);
        int          last   = 5;
        logic [15:0] prev   = pre;
        logic [15:0] want, seen;
        e.g = g; e.err = 4'd0; e.fidx = 3'd7; e.fval = 16'h0;
        for (int k = 0; k < 6; k++) begin
            want = va[k] & vb[k];
            case (md)
                0:       seen = want;
                1:       seen = 16'h0;
                2:       seen = (settle >= 2) ? want : prev;
                default: seen = m[k] ? (want ^ xv) : want;
            endcase
            prev = want;
            if (seen !== want) begin
                if (e.err != 4'd15) e.err = e.err + 4'd1;
                if (e.fidx == 3'd7) begin
                    e.fidx = 3'(k);
                    e.fval = seen;
                end
                if (stop) begin
                    last = k;
                    break;
                end
            end
        end
        e.lat     = (last + 1) * (2 + settle);
        e.nvec    = last + 1;
        e.pss     = (e.err == 4'd0);
        e.fin_and = va[last] & vb[last];
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        logic [15:0] p1, p2, p3;

        always @(posedge clk) begin
            if (reset) begin
                p1 <= 16'h0; p2 <= 16'h0; p3 <= 16'h0;
            end else begin
                p1 <= dut_a[g] & dut_b[g];
                p2 <= p1;
                p3 <= p2;
            end
        end

        always_comb begin
            case (mode[g])
                0:       dut_out[g] = dut_a[g] & dut_b[g];
                1:       dut_out[g] = 16'h0000;
                2:       dut_out[g] = p3;
                default: dut_out[g] = (dut_a[g] & dut_b[g]) ^
                                      (vec_hit(dut_a[g], dut_b[g], fmask[g]) ? fxor[g] : 16'h0000);
            endcase
        end

        and16_bist #(
            .SETTLE       ((g == 2) ? 4 : 1),
            .STOP_ON_FAIL (g == 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[g]),
            .dut_a      (dut_a[g]),
            .dut_b      (dut_b[g]),
            .dut_out    (dut_out[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .err_count  (err_count[g]),
            .fail_index (fail_index[g]),
            .fail_value (fail_value[g])
        );

        initial begin : mon
            bit          in_run;
            bit          bad_pass;
            int          cnt;
            int          idx;
            int          nv;
            logic [31:0] seen_v[$];
            exp_t        e;
            in_run   = 1'b0;
            bad_pass = 1'b0;
            cnt      = 0;
            forever begin
                @(negedge clk);
                if (pass[g] && !done[g]) bad_pass = 1'b1;
                if (reset) begin
                    in_run = 1'b0;
                    continue;
                end
                if (!in_run) begin
                    if (busy[g]) begin
                        in_run = 1'b1;
                        cnt    = 0;
                        seen_v.delete();
                        seen_v.push_back({dut_a[g], dut_b[g]});
                    end
                end else begin
                    cnt++;
                    if (busy[g] && {dut_a[g], dut_b[g]} != seen_v[$])
                        seen_v.push_back({dut_a[g], dut_b[g]});
                    if (done[g]) begin
                        in_run = 1'b0;
                        idx    = -1;
                        foreach (sb[i]) if (idx < 0 && sb[i].g == g) idx = i;
                        if (idx < 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_done inst%0d: got done expected none", g);
                        end else begin
                            e = sb[idx];
                            sb.delete(idx);
                            check("latency",    g, cnt,             e.lat);
                            check("err_count",  g, err_count[g],    e.err);
                            check("fail_index", g, fail_index[g],   e.fidx);
                            check("fail_value", g, fail_value[g],   e.fval);
                            check("pass",       g, pass[g],         e.pss);
                            check("vec_count",  g, seen_v.size(),   e.nvec);
                            nv = (seen_v.size() < e.nvec) ? seen_v.size() : e.nvec;
                            for (int i = 0; i < nv; i++)
                                check("operands", g, seen_v[i], {va[i], vb[i]});
                            check("pass_outside_done", g, bad_pass, 1'b0);
                            bad_pass = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int g, input int md, input logic [5:0] m, input logic [15:0] xv);
        exp_t e;
        mode[g]  = md;
        fmask[g] = m;
        fxor[g]  = xv;
        e = model(g, md, m, xv, pre_and[g]);
        pre_and[g] = e.fin_and;
        sb.push_back(e);
    endtask

    task automatic pulse_start(input int g);
        @(negedge clk);
        start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0; mode[g] = 0; fmask[g] = 6'h0; fxor[g] = 16'h0; pre_and[g] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_busy",  g, busy[g],       1'b0);
            check("rst_done",  g, done[g],       1'b0);
            check("rst_pass",  g, pass[g],       1'b0);
            check("rst_err",   g, err_count[g],  4'd0);
            check("rst_fidx",  g, fail_index[g], 3'd7);
            check("rst_fval",  g, fail_value[g], 16'h0);
            check("rst_ops",   g, {dut_a[g], dut_b[g]}, 32'h0);
        end
        reset = 1'b0;

        issue(0, 0, 6'h0, 16'h0); pulse_start(0); wait_drain();
        issue(0, 1, 6'h0, 16'h0); pulse_start(0); wait_drain();
        issue(1, 1, 6'h0, 16'h0); pulse_start(1); wait_drain();
        issue(2, 2, 6'h0, 16'h0); pulse_start(2); wait_drain();
        issue(0, 2, 6'h0, 16'h0); pulse_start(0); wait_drain();

        // Reset during WAIT of vector 3 (start edge + 10 edges puts us there).
        mode[0] = 1;
        pulse_start(0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_err", 0, err_count[0], 4'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_busy", 0, busy[0],       1'b0);
        check("mid_reset_done", 0, done[0],       1'b0);
        check("mid_reset_err",  0, err_count[0],  4'd0);
        check("mid_reset_fidx", 0, fail_index[0], 3'd7);
        check("mid_reset_ops",  0, {dut_a[0], dut_b[0]}, 32'h0);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) pre_and[g] = 16'h0;
        issue(0, 0, 6'h0, 16'h0); pulse_start(0); wait_drain();

        // Start held high across a whole run, then restart from DONE.
        issue(0, 1, 6'h0, 16'h0);
        issue(0, 1, 6'h0, 16'h0);
        @(negedge clk);
        start[0] = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done[0] && t < 100);
        check("held_done_seen", 0, done[0], 1'b1);
        @(posedge clk);
        #1 start[0] = 1'b0;
        check("restart_err",  0, err_count[0],  4'd0);
        check("restart_fidx", 0, fail_index[0], 3'd7);
        check("restart_fval", 0, fail_value[0], 16'h0);
        check("restart_busy", 0, busy[0],       1'b1);
        check("restart_done", 0, done[0],       1'b0);
        wait_drain();

        repeat (20) begin
            int g, md;
            g  = $urandom_range(0, 2);
            md = $urandom_range(0, 3);
            issue(g, md, 6'($urandom), 16'($urandom_range(1, 16'hFFFF)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start(g);
            wait_drain();
        end

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
